move_queue_sequencer: RTL and testbench
=======================================

MOVE_QUEUE_SEQUENCER -- requirements
Module: move_queue_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning move-command FIFO depth (power of two, 2..16).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 1000000, meaning the maximum Clock100Mhz cycles StepWrite is held while awaiting driver start.
REQ-003 Clock100Mhz  input  1  sole clock, all logic rising-edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 CmdValid  input  1  upstream move command present.
REQ-006 CmdReady  output  1  FIFO can accept a command.
REQ-007 CmdStepCount  input  20  steps for the move.
REQ-008 CmdFeedRate  input  20  clock-divider value for the move.
REQ-009 CmdDirection  input  1  1 = toward LimitEnd, 0 = toward LimitStart.
REQ-010 Abort  input  1  flush queue and stop issuing.
REQ-011 FaultClear  input  1  clears sticky fault flags.
REQ-012 LimitStart, LimitEnd  input  1 each  endstop levels, already synchronised.
REQ-013 Waiting  input  1  stepper driver idle (1) / running (0).
REQ-014 StepWrite  output  1  start request to stepper driver.
REQ-015 StepCount, FeedRate  output  20 each  registered move parameters to the driver.
REQ-016 Direction  output  1  registered direction to the driver.
REQ-017 Busy  output  1  FSM not in IDLE or FIFO not empty.
REQ-018 QueueLevel  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-019 LimitFault, TimeoutFault  output  1 each  sticky fault flags.

Function
REQ-020 FIFO write SHALL occur on a cycle with CmdValid=1 and CmdReady=1; CmdReady SHALL equal (QueueLevel<DEPTH) and not Abort.
REQ-021 Simultaneous write and pop SHALL leave QueueLevel unchanged; pointers SHALL wrap modulo DEPTH.
REQ-022 FSM states SHALL be IDLE, LOAD, ISSUE, RUN, DRAIN.
REQ-023 IDLE -> LOAD when FIFO non-empty and Waiting=1; LOAD pops the head into StepCount/FeedRate/Direction in one cycle.
REQ-024 LOAD -> IDLE without asserting StepWrite when the popped StepCount is 0 (command discarded, no fault).
REQ-025 LOAD -> IDLE without asserting StepWrite and SHALL set LimitFault when (Direction=1 and LimitEnd=1) or (Direction=0 and LimitStart=1).
REQ-026 Otherwise LOAD -> ISSUE; in ISSUE StepWrite SHALL be 1, held until Waiting=0 is sampled, then ISSUE -> RUN with StepWrite=0 the next cycle.
REQ-027 ISSUE SHALL count cycles; on reaching ACK_TIMEOUT with Waiting still 1, StepWrite SHALL drop, TimeoutFault SHALL set, FIFO SHALL flush, FSM -> IDLE.
REQ-028 RUN -> IDLE when Waiting=1 is sampled; earliest next LOAD is the following cycle.
REQ-029 StepCount, FeedRate, Direction SHALL stay stable from LOAD until the FSM next enters LOAD.
REQ-030 Abort=1 SHALL flush the FIFO (QueueLevel=0 next cycle) in any state; in IDLE/LOAD -> IDLE; in ISSUE drop StepWrite -> DRAIN; in RUN -> DRAIN.
REQ-031 DRAIN -> IDLE when Waiting=1; no command is issued while in DRAIN.
REQ-032 While LimitFault or TimeoutFault is 1, IDLE SHALL NOT leave for LOAD; FIFO still accepts commands.
REQ-033 FaultClear=1 SHALL clear both flags next cycle; a same-cycle set takes priority over clear.

Reset
REQ-034 Reset=0 SHALL immediately force FSM=IDLE, FIFO empty, QueueLevel=0, StepWrite=0, StepCount=0, FeedRate=0, Direction=0, LimitFault=0, TimeoutFault=0, Busy=0, CmdReady=0 while low.
REQ-035 Reset asserted mid-move SHALL drop StepWrite asynchronously; after release the block SHALL wait for Waiting=1 before any issue.

Verification
REQ-036 Push 3 commands (100/500/0, 200/500/1, 50/1000/1), model driver Waiting low 30 cycles after StepWrite -> exactly 3 StepWrite pulses, outputs match each command in order.
REQ-037 Fill FIFO with DEPTH commands, Waiting held 0 -> CmdReady=0, QueueLevel=DEPTH, 5th CmdValid not accepted; level unchanged on simultaneous push/pop.
REQ-038 Command StepCount=0 followed by StepCount=10 -> no StepWrite for the first, one StepWrite for the second, no fault.
REQ-039 LimitEnd=1, command Direction=1 -> no StepWrite, LimitFault=1; further queued commands stall until FaultClear pulse, then issue.
REQ-040 ACK_TIMEOUT=16, Waiting stuck 1 -> StepWrite high exactly 16 cycles, TimeoutFault=1, QueueLevel=0.
REQ-041 Abort during RUN with 2 queued -> QueueLevel=0 next cycle, Busy stays 1 until Waiting=1, no further StepWrite; Reset=0 mid-ISSUE -> StepWrite=0 without a clock edge.

Source files
------------

// File: rtl/move_queue_sequencer.sv
// move_queue_sequencer
// Buffers upstream move commands in a small FIFO and hands them one at a
// time to a stepper driver using a StepWrite / Waiting handshake. It skips
// zero-length moves, refuses moves into an active endstop, times out a
// driver that never starts, and honours an abort that flushes the queue.
//
// Ports
//   Clock100Mhz   : sole clock, rising edge
//   Reset         : asynchronous, active-low
//   CmdValid/CmdReady, CmdStepCount, CmdFeedRate, CmdDirection : command input
//   Abort         : flush queue and stop issuing
//   FaultClear    : clears LimitFault and TimeoutFault
//   LimitStart/LimitEnd : synchronised endstop levels
//   Waiting       : driver idle (1) / running (0)
//   StepWrite     : start request to the driver
//   StepCount, FeedRate, Direction : move parameters held for the driver
//   Busy          : sequencer active or commands pending
//   QueueLevel    : FIFO occupancy
//   LimitFault, TimeoutFault : sticky fault flags
module move_queue_sequencer #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_TIMEOUT = 1000000,
  localparam int unsigned MOVE_W     = 20,
  localparam int unsigned PTR_W      = $clog2(DEPTH),
  localparam int unsigned LVL_W      = PTR_W + 1
) (
  input  logic              Clock100Mhz,
  input  logic              Reset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [MOVE_W-1:0] CmdStepCount,
  input  logic [MOVE_W-1:0] CmdFeedRate,
  input  logic              CmdDirection,
  input  logic              Abort,
  input  logic              FaultClear,
  input  logic              LimitStart,
  input  logic              LimitEnd,
  input  logic              Waiting,
  output logic              StepWrite,
  output logic [MOVE_W-1:0] StepCount,
  output logic [MOVE_W-1:0] FeedRate,
  output logic              Direction,
  output logic              Busy,
  output logic [LVL_W-1:0]  QueueLevel,
  output logic              LimitFault,
  output logic              TimeoutFault
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef struct packed {
    logic [MOVE_W-1:0] step_count;
    logic [MOVE_W-1:0] feed_rate;
    logic              direction;
  } move_cmd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;

  move_cmd_t         mem [DEPTH];
  move_cmd_t         cmd_in;
  move_cmd_t         head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_addr;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  issue_cnt;

  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              flush;
  logic              load_en;
  logic              limit_hit;
  logic              limit_set;
  logic              timeout_set;

  assign cmd_in     = '{step_count: CmdStepCount, feed_rate: CmdFeedRate, direction: CmdDirection};
  assign head       = mem[rd_ptr];
  assign fifo_empty = (level == '0);
  assign limit_hit  = head.direction ? LimitEnd : LimitStart;

  // Reset gating keeps the handshake closed while the block is held in reset.
  assign CmdReady   = Reset & (level < LVL_W'(DEPTH)) & ~Abort;
  assign push       = CmdValid & CmdReady;

  // A flush resets both pointers, so a write landing in the same cycle goes to slot 0.
  assign wr_addr    = flush ? '0 : wr_ptr;

  // Decoded from the state register, so reset drops StepWrite without a clock edge.
  assign StepWrite  = (state == ISSUE);
  assign Busy       = (state != IDLE) | ~fifo_empty;
  assign QueueLevel = level;

  // State register.
  always_ff @(posedge Clock100Mhz or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    load_en     = 1'b0;
    flush       = Abort;
    limit_set   = 1'b0;
    timeout_set = 1'b0;

    case (state)
      IDLE: begin
        if (!Abort && !fifo_empty && Waiting && !LimitFault && !TimeoutFault) begin
          state_next = LOAD;
        end
      end

      LOAD: begin
        if (Abort) begin
          state_next = IDLE;
        end else begin
          pop     = 1'b1;
          load_en = 1'b1;
          if (head.step_count == '0) begin
            state_next = IDLE;
          end else if (limit_hit) begin
            limit_set  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (Abort) begin
          state_next = DRAIN;
        end else if (!Waiting) begin
          state_next = RUN;
        end else if (issue_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Driver never acknowledged: give up and discard everything queued.
          timeout_set = 1'b1;
          flush       = 1'b1;
          state_next  = IDLE;
        end
      end

      RUN: begin
        if (Abort) begin
          state_next = DRAIN;
        end else if (Waiting) begin
          state_next = IDLE;
        end
      end

      DRAIN: begin
        if (Waiting) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge Clock100Mhz) begin
    if (push) begin
      mem[wr_addr] <= cmd_in;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge Clock100Mhz or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PTR_W'(1) : '0;
      level  <= push ? LVL_W'(1) : '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Cycles spent in ISSUE; restarts from zero on every entry.
  always_ff @(posedge Clock100Mhz or negedge Reset) begin
    if (!Reset) begin
      issue_cnt <= '0;
    end else if (state == ISSUE) begin
      issue_cnt <= issue_cnt + CNT_W'(1);
    end else begin
      issue_cnt <= '0;
    end
  end

  // Move parameters latched at LOAD and held until the next LOAD.
  always_ff @(posedge Clock100Mhz or negedge Reset) begin
    if (!Reset) begin
      StepCount <= '0;
      FeedRate  <= '0;
      Direction <= 1'b0;
    end else if (load_en) begin
      StepCount <= head.step_count;
      FeedRate  <= head.feed_rate;
      Direction <= head.direction;
    end
  end

  // Sticky faults; a set in the same cycle wins over FaultClear.
  always_ff @(posedge Clock100Mhz or negedge Reset) begin
    if (!Reset) begin
      LimitFault   <= 1'b0;
      TimeoutFault <= 1'b0;
    end else begin
      if (limit_set) begin
        LimitFault <= 1'b1;
      end else if (FaultClear) begin
        LimitFault <= 1'b0;
      end
      if (timeout_set) begin
        TimeoutFault <= 1'b1;
      end else if (FaultClear) begin
        TimeoutFault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_move_queue_sequencer.sv
// Directed bench for move_queue_sequencer (DEPTH=4, ACK_TIMEOUT=16).
module tb_move_queue_sequencer;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned ACK_TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [19:0] cmd_sc;
  logic [19:0] cmd_fr;
  logic        cmd_dir;
  logic        abort;
  logic        fault_clear;
  logic        limit_start;
  logic        limit_end;
  logic        waiting;
  logic        step_write;
  logic [19:0] step_count;
  logic [19:0] feed_rate;
  logic        direction;
  logic        busy;
  logic [2:0]  level;
  logic        limit_fault;
  logic        timeout_fault;

  int checks   = 0;
  int failures = 0;

  // Driver-model observations
  int          pulses;
  int          drv_busy;
  logic [19:0] obs_sc  [8];
  logic [19:0] obs_fr  [8];
  logic        obs_dir [8];

  move_queue_sequencer #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .Clock100Mhz  (clk),
    .Reset        (reset),
    .CmdValid     (cmd_valid),
    .CmdReady     (cmd_ready),
    .CmdStepCount (cmd_sc),
    .CmdFeedRate  (cmd_fr),
    .CmdDirection (cmd_dir),
    .Abort        (abort),
    .FaultClear   (fault_clear),
    .LimitStart   (limit_start),
    .LimitEnd     (limit_end),
    .Waiting      (waiting),
    .StepWrite    (step_write),
    .StepCount    (step_count),
    .FeedRate     (feed_rate),
    .Direction    (direction),
    .Busy         (busy),
    .QueueLevel   (level),
    .LimitFault   (limit_fault),
    .TimeoutFault (timeout_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [19:0] sc, input logic [19:0] fr, input logic dir);
    cmd_valid = 1'b1;
    cmd_sc    = sc;
    cmd_fr    = fr;
    cmd_dir   = dir;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Stepper driver model: on StepWrite while idle, run for 30 cycles.
  task automatic run_driver(input int cycles);
    pulses   = 0;
    drv_busy = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (drv_busy > 0) begin
        drv_busy--;
        if (drv_busy == 0) waiting = 1'b1;
      end else if (step_write === 1'b1 && waiting) begin
        if (pulses < 8) begin
          obs_sc[pulses]  = step_count;
          obs_fr[pulses]  = feed_rate;
          obs_dir[pulses] = direction;
        end
        pulses++;
        waiting  = 1'b0;
        drv_busy = 30;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; cmd_sc = 20'd1; cmd_fr = 20'd1; cmd_dir = 1'b0;
    abort = 1'b0; fault_clear = 1'b0; limit_start = 1'b0; limit_end = 1'b0; waiting = 1'b1;
    #1 reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
    checks++; if (step_write !== 1'b0) begin failures++; $display("FAIL rst_stepwrite got=%b exp=0", step_write); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if ({step_count, feed_rate, direction} !== 41'd0) begin failures++;
      $display("FAIL rst_move got=%0d/%0d/%b exp=0/0/0", step_count, feed_rate, direction); end
    checks++; if ({limit_fault, timeout_fault} !== 2'b00) begin failures++;
      $display("FAIL rst_faults got=%b%b exp=00", limit_fault, timeout_fault); end
    tick(); tick();
    checks++; if (level !== 3'd0 || cmd_ready !== 1'b0) begin failures++;
      $display("FAIL rst_hold got level=%0d ready=%b exp level=0 ready=0", level, cmd_ready); end
    cmd_valid = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin failures++;
      $display("FAIL rst_release got ready=%b busy=%b exp ready=1 busy=0", cmd_ready, busy); end
  endtask

  task automatic test_sequence();
    logic [19:0] exp_sc  [3];
    logic [19:0] exp_fr  [3];
    logic        exp_dir [3];
    exp_sc  = '{20'd100, 20'd200, 20'd50};
    exp_fr  = '{20'd500, 20'd500, 20'd1000};
    exp_dir = '{1'b0, 1'b1, 1'b1};
    waiting = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(exp_sc[i], exp_fr[i], exp_dir[i]);
    checks++; if (level !== 3'd3) begin failures++; $display("FAIL seq_level got=%0d exp=3", level); end
    waiting = 1'b1;
    run_driver(200);
    checks++; if (pulses !== 3) begin failures++; $display("FAIL seq_pulses got=%0d exp=3", pulses); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_sc[i] !== exp_sc[i] || obs_fr[i] !== exp_fr[i] || obs_dir[i] !== exp_dir[i]) begin
        failures++;
        $display("FAIL seq_move[%0d] got=%0d/%0d/%b exp=%0d/%0d/%b", i, obs_sc[i], obs_fr[i], obs_dir[i],
                 exp_sc[i], exp_fr[i], exp_dir[i]);
      end
    end
    checks++; if (busy !== 1'b0 || level !== 3'd0) begin failures++;
      $display("FAIL seq_idle got busy=%b level=%0d exp busy=0 level=0", busy, level); end
  endtask

  task automatic test_fill();
    waiting = 1'b0;
    for (int i = 1; i <= 4; i++) push_cmd(20'(i), 20'(i), 1'(i / 3));
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL fill_level got=%0d exp=4", level); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", cmd_ready); end
    push_cmd(20'd5, 20'd5, 1'b0);
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL fill_fifth got=%0d exp=4", level); end
    abort = 1'b1;
    tick();
    checks++; if (level !== 3'd0 || cmd_ready !== 1'b0) begin failures++;
      $display("FAIL fill_abort got level=%0d ready=%b exp level=0 ready=0", level, cmd_ready); end
    abort = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_back got=%b exp=1", cmd_ready); end
    // Simultaneous push and pop
    push_cmd(20'd11, 20'd12, 1'b1);
    waiting = 1'b1;
    tick();
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL pp_before got=%0d exp=1", level); end
    cmd_valid = 1'b1; cmd_sc = 20'd21; cmd_fr = 20'd22; cmd_dir = 1'b0;
    tick();
    cmd_valid = 1'b0;
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL pp_level got=%0d exp=1", level); end
    checks++; if (step_write !== 1'b1 || step_count !== 20'd11) begin failures++;
      $display("FAIL pp_issue got sw=%b sc=%0d exp sw=1 sc=11", step_write, step_count); end
    abort = 1'b1;
    tick();
    checks++; if (level !== 3'd0 || step_write !== 1'b0 || busy !== 1'b1) begin failures++;
      $display("FAIL issue_abort got level=%0d sw=%b busy=%b exp 0/0/1", level, step_write, busy); end
    abort = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_exit got busy=%b exp=0", busy); end
  endtask

  task automatic test_zero_step();
    waiting = 1'b0;
    push_cmd(20'd0, 20'd7, 1'b0);
    push_cmd(20'd10, 20'd8, 1'b1);
    waiting = 1'b1;
    run_driver(100);
    checks++; if (pulses !== 1) begin failures++; $display("FAIL zero_pulses got=%0d exp=1", pulses); end
    checks++; if (obs_sc[0] !== 20'd10 || obs_fr[0] !== 20'd8 || obs_dir[0] !== 1'b1) begin failures++;
      $display("FAIL zero_move got=%0d/%0d/%b exp=10/8/1", obs_sc[0], obs_fr[0], obs_dir[0]); end
    checks++; if ({limit_fault, timeout_fault} !== 2'b00 || level !== 3'd0) begin failures++;
      $display("FAIL zero_faults got=%b%b level=%0d exp=00 level=0", limit_fault, timeout_fault, level); end
  endtask

  task automatic test_limit();
    limit_end = 1'b1;
    waiting   = 1'b0;
    push_cmd(20'd5, 20'd9, 1'b1);
    push_cmd(20'd6, 20'd9, 1'b0);
    waiting = 1'b1;
    run_driver(20);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL limit_pulses got=%0d exp=0", pulses); end
    checks++; if (limit_fault !== 1'b1 || timeout_fault !== 1'b0) begin failures++;
      $display("FAIL limit_fault got=%b%b exp=10", limit_fault, timeout_fault); end
    checks++; if (level !== 3'd1 || busy !== 1'b1) begin failures++;
      $display("FAIL limit_stall got level=%0d busy=%b exp level=1 busy=1", level, busy); end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    checks++; if (limit_fault !== 1'b0) begin failures++; $display("FAIL limit_clear got=%b exp=0", limit_fault); end
    run_driver(60);
    checks++; if (pulses !== 1 || obs_sc[0] !== 20'd6 || obs_dir[0] !== 1'b0) begin failures++;
      $display("FAIL limit_resume got pulses=%0d sc=%0d dir=%b exp 1/6/0", pulses, obs_sc[0], obs_dir[0]); end
    limit_end = 1'b0;
  endtask

  task automatic test_timeout();
    int   hi;
    logic prev_sw;
    logic tf_drop;
    logic [2:0] lvl_drop;
    hi = 0; prev_sw = 1'b0; tf_drop = 1'b0; lvl_drop = 3'd7;
    waiting = 1'b1;
    push_cmd(20'd3, 20'd4, 1'b0);
    push_cmd(20'd8, 20'd8, 1'b1);
    fault_clear = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (step_write === 1'b1) hi++;
      if (prev_sw === 1'b1 && step_write === 1'b0) begin
        tf_drop  = timeout_fault;
        lvl_drop = level;
      end
      prev_sw = step_write;
    end
    fault_clear = 1'b0;
    checks++; if (hi !== ACK_TIMEOUT) begin failures++; $display("FAIL to_width got=%0d exp=%0d", hi, ACK_TIMEOUT); end
    checks++; if (tf_drop !== 1'b1) begin failures++; $display("FAIL to_fault got=%b exp=1", tf_drop); end
    checks++; if (lvl_drop !== 3'd0) begin failures++; $display("FAIL to_flush got=%0d exp=0", lvl_drop); end
    checks++; if (timeout_fault !== 1'b0 || step_count !== 20'd3) begin failures++;
      $display("FAIL to_after got tf=%b sc=%0d exp tf=0 sc=3", timeout_fault, step_count); end
  endtask

  task automatic test_abort_run();
    logic bad;
    waiting = 1'b0;
    push_cmd(20'd30, 20'd1, 1'b0);
    push_cmd(20'd31, 20'd1, 1'b0);
    push_cmd(20'd32, 20'd1, 1'b0);
    waiting = 1'b1;
    tick(); tick();
    checks++; if (step_write !== 1'b1 || level !== 3'd2) begin failures++;
      $display("FAIL ar_issue got sw=%b level=%0d exp sw=1 level=2", step_write, level); end
    waiting = 1'b0;
    tick();
    checks++; if (step_write !== 1'b0) begin failures++; $display("FAIL ar_run got sw=%b exp=0", step_write); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (level !== 3'd0 || busy !== 1'b1) begin failures++;
      $display("FAIL ar_flush got level=%0d busy=%b exp level=0 busy=1", level, busy); end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (step_write !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL ar_drain got bad=%b exp=0", bad); end
    waiting = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_idle got busy=%b exp=0", busy); end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (step_write !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL ar_no_issue got bad=%b exp=0", bad); end

    // Reset asserted while StepWrite is high
    push_cmd(20'd7, 20'd7, 1'b0);
    tick(); tick();
    checks++; if (step_write !== 1'b1) begin failures++; $display("FAIL rm_issue got sw=%b exp=1", step_write); end
    #3 reset = 1'b0;
    #1;
    checks++; if (step_write !== 1'b0 || level !== 3'd0 || step_count !== 20'd0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL rm_async got sw=%b level=%0d sc=%0d ready=%b exp 0/0/0/0", step_write, level, step_count, cmd_ready);
    end
    tick();
    reset   = 1'b1;
    waiting = 1'b0;
    push_cmd(20'd9, 20'd9, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (step_write !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0 || level !== 3'd1) begin failures++;
      $display("FAIL rm_wait got bad=%b level=%0d exp bad=0 level=1", bad, level); end
    waiting = 1'b1;
    run_driver(50);
    checks++; if (pulses !== 1 || obs_sc[0] !== 20'd9) begin failures++;
      $display("FAIL rm_resume got pulses=%0d sc=%0d exp 1/9", pulses, obs_sc[0]); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_fill();
    test_zero_step();
    test_limit();
    test_timeout();
    test_abort_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
